// File: rtl/onehot_sched_pkg.sv
// Shared types and helpers for the one-hot grant scheduler.
package onehot_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_t;

    // Hold counter sized for the largest legal HOLD_MAX so every instance shares one width.
    localparam int HOLD_MAX_LIMIT = 255;
    localparam int HOLD_W         = $clog2(HOLD_MAX_LIMIT + 1);

    function automatic logic [15:0] idx2onehot(input logic [3:0] idx);
        logic [15:0] oh;
        unique case (idx)
            4'd0:    oh = 16'h0001;
            4'd1:    oh = 16'h0002;
            4'd2:    oh = 16'h0004;
            4'd3:    oh = 16'h0008;
            4'd4:    oh = 16'h0010;
            4'd5:    oh = 16'h0020;
            4'd6:    oh = 16'h0040;
            4'd7:    oh = 16'h0080;
            4'd8:    oh = 16'h0100;
            4'd9:    oh = 16'h0200;
            4'd10:   oh = 16'h0400;
            4'd11:   oh = 16'h0800;
            4'd12:   oh = 16'h1000;
            4'd13:   oh = 16'h2000;
            4'd14:   oh = 16'h4000;
            4'd15:   oh = 16'h8000;
            default: oh = 16'h0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/onehot_grant_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, cyclic.
module onehot_grant_scheduler_rr_pick #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rot_s;
    logic [IDX_W-1:0] pos_s;

    // Rotate so that rr_ptr lands on bit 0.
    always_comb begin
        rot_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int j;
            j = i + int'(rr_ptr);
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end else begin
                j = j;
            end
            rot_s[i] = req[j];
        end
    end

    // Lowest set bit of the rotated vector wins.
    always_comb begin
        pos_s = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            pos_s = rot_s[i] ? IDX_W'(i) : pos_s;
        end
    end

    // Rotate back; result stays below N_REQ even for non-power-of-two sizes.
    always_comb begin
        int s;
        any = |rot_s;
        s   = int'(pos_s) + int'(rr_ptr);
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end else begin
            s = s;
        end
        idx = any ? IDX_W'(s) : '0;
    end

endmodule

// File: rtl/onehot_grant_scheduler.sv
// Round-robin grant scheduler with hold limit, optional dead cycle and registered one-hot outputs.
module onehot_grant_scheduler
    import onehot_sched_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int HOLD_MAX = 15,
    parameter int GAP_EN   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [N_REQ-1:0]         req,
    output logic                     grant_valid,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic [N_REQ-1:0]         grant_onehot,
    output logic                     hold_expired
);

    localparam int                IDX_W    = $clog2(N_REQ);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_REQ - 1);

    sched_state_t       state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic               expired_q, expired_d;

    logic               grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0]   grant_onehot_q, grant_onehot_d;
    logic               hold_expired_q, hold_expired_d;

    logic               pick_any_s;
    logic [IDX_W-1:0]   pick_idx_s;
    logic [15:0]        own_oh16_s;
    logic [N_REQ-1:0]   own_oh_s;
    logic               own_req_s;
    logic               others_s;
    logic               release_s;
    logic [IDX_W-1:0]   next_ptr_s;

    onehot_grant_scheduler_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .any    (pick_any_s),
        .idx    (pick_idx_s)
    );

    assign own_oh16_s = idx2onehot(4'(idx_q));
    assign own_oh_s   = N_REQ'(own_oh16_s);
    assign own_req_s  = req[idx_q];
    assign others_s   = |(req & ~own_oh_s);
    assign next_ptr_s = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);

    // Next-state logic: pick, hold counting, release and pointer advance.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        expired_d  = 1'b0;
        release_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && pick_any_s) begin
                    state_d    = GRANT;
                    idx_d      = pick_idx_s;
                    hold_cnt_d = HOLD_W'(1);
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                if (!own_req_s) begin
                    release_s  = 1'b1;
                end else if (hold_cnt_q < HOLD_LIM) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end else if (others_s) begin
                    release_s  = 1'b1;
                    expired_d  = 1'b1;
                end else begin
                    hold_cnt_d = HOLD_LIM;
                end
                if (release_s) begin
                    rr_ptr_d   = next_ptr_s;
                    hold_cnt_d = '0;
                    state_d    = (GAP_EN != 0) ? GAP : IDLE;
                end else begin
                    state_d    = GRANT;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage is a registered view of the scheduling state, one cycle behind it.
    always_comb begin
        grant_valid_d  = (state_q == GRANT);
        grant_idx_d    = idx_q;
        grant_onehot_d = grant_valid_d ? own_oh_s : '0;
        hold_expired_d = expired_q;
    end

    // Scheduling state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            expired_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            expired_q  <= expired_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            hold_expired_q <= 1'b0;
        end else begin
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            hold_expired_q <= hold_expired_d;
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;
    assign hold_expired = hold_expired_q;

endmodule

// File: tb/tb_onehot_grant_scheduler.sv
// Randomized and directed bench for onehot_grant_scheduler against a behavioural reference model.
module tb_onehot_grant_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] req;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_onehot;
    logic       hold_expired;

    int checks   = 0;
    int failures = 0;

    // Reference model: scheduling phase (0 idle, 1 granted, 2 dead cycle) and visible outputs.
    int         m_phase;
    int         m_cnt;
    logic [2:0] m_owner;
    logic [2:0] m_ptr;
    logic       m_expflag;
    logic       e_valid;
    logic [2:0] e_idx;
    logic [7:0] e_onehot;
    logic       e_exp;
    logic [12:0] got;
    logic [12:0] want;

    localparam int HOLD = 15;

    onehot_grant_scheduler #(
        .N_REQ    (8),
        .HOLD_MAX (HOLD),
        .GAP_EN   (1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req          (req),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .hold_expired (hold_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase   = 0;
        m_cnt     = 0;
        m_owner   = 3'd0;
        m_ptr     = 3'd0;
        m_expflag = 1'b0;
        e_valid   = 1'b0;
        e_idx     = 3'd0;
        e_onehot  = 8'h00;
        e_exp     = 1'b0;
    endtask

    function automatic int model_pick(input logic [7:0] r, input int ptr);
        for (int k = 0; k < 8; k++) begin
            if (r[(ptr + k) % 8]) return (ptr + k) % 8;
        end
        return -1;
    endfunction

    // One clock edge of the scheduler as described by its rules; outputs lag decisions by one cycle.
    task automatic model_edge(input logic [7:0] r, input logic en);
        int  w;
        bit  stop;
        e_valid   = (m_phase == 1);
        e_idx     = m_owner;
        e_onehot  = e_valid ? (8'h01 << m_owner) : 8'h00;
        e_exp     = m_expflag;
        m_expflag = 1'b0;
        if (m_phase == 0) begin
            w = model_pick(r, int'(m_ptr));
            if (en && w >= 0) begin
                m_phase = 1;
                m_owner = 3'(w);
                m_cnt   = 1;
            end
        end else if (m_phase == 1) begin
            stop = 0;
            if (!r[m_owner]) stop = 1;
            else if (m_cnt < HOLD) m_cnt = m_cnt + 1;
            else if ((r & ~(8'h01 << m_owner)) != 8'h00) begin
                stop      = 1;
                m_expflag = 1'b1;
            end
            if (stop) begin
                m_ptr   = 3'((int'(m_owner) + 1) % 8);
                m_phase = 2;
                m_cnt   = 0;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    task automatic step(input logic [7:0] r, input logic en);
        req    = r;
        enable = en;
        @(posedge clk);
        model_edge(r, en);
        @(negedge clk);
        got  = {grant_valid, grant_idx, grant_onehot, hold_expired};
        want = {e_valid, e_idx, e_onehot, e_exp};
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        req    = 8'h00;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        req    = 8'hFF;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant_valid, grant_idx, grant_onehot, hold_expired} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b i=%0d oh=%h x=%b, want all zero",
                     grant_valid, grant_idx, grant_onehot, hold_expired);
        end
        model_reset();
        rst_n = 1'b1;
        for (int s = 1; s <= 3; s++) begin
            step(8'hFF, 1'b1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_release step %0d: got %h want %h", s, got, want);
            end
            if (s == 2) begin
                checks++;
                if (grant_valid !== 1'b1 || grant_idx !== 3'd0 || grant_onehot !== 8'h01) begin
                    failures++;
                    $display("FAIL reset_first_grant: got v=%b i=%0d oh=%h want v=1 i=0 oh=01",
                             grant_valid, grant_idx, grant_onehot);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        int         run;
        logic [7:0] r;
        logic       prev_v;
        int         order[$];
        do_reset();
        run    = 0;
        prev_v = 1'b0;
        for (int s = 0; s < 200 && order.size() < 9; s++) begin
            r = 8'hFF;
            if (e_valid && run >= 2) r[e_idx] = 1'b0;
            step(r, 1'b1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL rr_step %0d: got %h want %h", s, got, want);
            end
            run = e_valid ? run + 1 : 0;
            if (grant_valid && !prev_v) order.push_back(int'(grant_idx));
            prev_v = grant_valid;
        end
        checks++;
        if (order.size() != 9) begin
            failures++;
            $display("FAIL rr_count: got %0d grants want 9", order.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (order[k] != (k % 8)) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], k % 8);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int   n0;
        int   pulses;
        int   first_other;
        do_reset();
        n0          = 0;
        pulses      = 0;
        first_other = -1;
        for (int s = 1; s <= 30; s++) begin
            step(8'h05, 1'b1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL timeout_step %0d: got %h want %h", s, got, want);
            end
            if (grant_valid && grant_idx == 3'd0) n0++;
            if (hold_expired) pulses++;
            if (grant_valid && grant_idx != 3'd0 && first_other < 0) first_other = int'(grant_idx);
        end
        checks++;
        if (n0 != HOLD || pulses != 1 || first_other != 2) begin
            failures++;
            $display("FAIL timeout_summary: got idx0_cycles=%0d pulses=%0d next=%0d want 15 1 2",
                     n0, pulses, first_other);
        end
    endtask

    task automatic test_sole();
        int n4;
        int pulses;
        do_reset();
        n4     = 0;
        pulses = 0;
        for (int s = 1; s <= 40; s++) begin
            step(8'h10, 1'b1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL sole_step %0d: got %h want %h", s, got, want);
            end
            if (grant_valid && grant_idx == 3'd4) n4++;
            if (hold_expired) pulses++;
        end
        checks++;
        if (n4 != 39 || pulses != 0) begin
            failures++;
            $display("FAIL sole_summary: got idx4_cycles=%0d pulses=%0d want 39 0", n4, pulses);
        end
    endtask

    task automatic test_wrap_enable();
        logic       prev_v;
        int         order[$];
        int         blocked;
        do_reset();
        for (int s = 0; s < 3; s++) step(8'h40, 1'b1);
        for (int s = 0; s < 4; s++) step(8'h00, 1'b1);
        blocked = 0;
        for (int s = 0; s < 6; s++) begin
            step(8'h81, 1'b0);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL wrap_disabled_step %0d: got %h want %h", s, got, want);
            end
            if (grant_valid) blocked++;
        end
        checks++;
        if (blocked != 0) begin
            failures++;
            $display("FAIL wrap_enable_block: got %0d grant cycles want 0", blocked);
        end
        prev_v = 1'b0;
        for (int s = 0; s < 40; s++) begin
            step(8'h81, 1'b1);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL wrap_step %0d: got %h want %h", s, got, want);
            end
            if (grant_valid && !prev_v) order.push_back(int'(grant_idx));
            prev_v = grant_valid;
        end
        checks++;
        if (order.size() < 2 || order[0] != 7 || order[1] != 0) begin
            failures++;
            $display("FAIL wrap_order: got %0d grants first=%0d second=%0d want 7 then 0",
                     order.size(), (order.size() > 0) ? order[0] : -1,
                     (order.size() > 1) ? order[1] : -1);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int s = 0; s < 4; s++) step(8'h08, 1'b1);
        checks++;
        if (grant_valid !== 1'b1 || grant_idx !== 3'd3 || grant_onehot !== 8'h08) begin
            failures++;
            $display("FAIL async_pre_grant: got v=%b i=%0d oh=%h want v=1 i=3 oh=08",
                     grant_valid, grant_idx, grant_onehot);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant_valid, grant_idx, grant_onehot, hold_expired} !== 13'd0) begin
            failures++;
            $display("FAIL async_reset_outputs: got v=%b i=%0d oh=%h x=%b want all zero",
                     grant_valid, grant_idx, grant_onehot, hold_expired);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        step(8'hFF, 1'b1);
        step(8'hFF, 1'b1);
        checks++;
        if (got !== want || grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            failures++;
            $display("FAIL async_ptr_cleared: got %h want %h (idx 0)", got, want);
        end
    endtask

    task automatic test_random();
        logic [7:0] r;
        logic       en;
        do_reset();
        r = 8'h00;
        for (int s = 0; s < 500; s++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom);
            else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
            en = ($urandom_range(0, 7) != 0);
            step(r, en);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL random_step %0d: req=%h en=%b got %h want %h", s, r, en, got, want);
            end
            checks++;
            if ($countones(grant_onehot) > 1) begin
                failures++;
                $display("FAIL random_onehot %0d: got %h want at most one bit", s, grant_onehot);
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        req    = 8'h00;
        enable = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_timeout();
        test_sole();
        test_wrap_enable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
